cpx_return_buffer: RTL and testbench

//  Elastic queue on the CPX return path, directly downstream of the CCX/L1.5 transducer's registered CPX output.

---
 rtl/ccx_pkg.sv | 15 +
 rtl/cpx_buf_ptr.sv | 56 +++++
 rtl/cpx_return_buffer.sv | 90 +++++++++
 tb/tb_cpx_return_buffer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccx_pkg.sv
// Shared CCX/CPX packet definitions used on the L1.5 <-> core return path.
// Field positions are fixed by the CPX packet format.
package ccx_pkg;

  localparam int CPX_WIDTH      = 145;
  localparam int CPX_VALID_BIT  = 144;
  localparam int CPX_ATOMIC_BIT = 129;
  localparam int CPX_RTNTYPE_HI = 143;
  localparam int CPX_RTNTYPE_LO = 140;

  function automatic logic cpx_is_atomic(input logic [CPX_WIDTH-1:0] pkt);
    return pkt[CPX_ATOMIC_BIT];
  endfunction

endpackage

// File: rtl/cpx_buf_ptr.sv
// Read/write pointers and occupancy for the CPX return buffer.
// Pointers wrap naturally because DEPTH is a power of two.
module cpx_buf_ptr #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enq_i,
  input  logic          deq_i,
  output logic [PW-1:0] wr_ptr_o,
  output logic [PW-1:0] rd_ptr_o,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] count_d_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (deq_i) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({enq_i, deq_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o  = wr_ptr_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign count_o   = count_q;
  assign count_d_o = count_d;
  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/cpx_return_buffer.sv
// Elastic CPX return queue: absorbs unthrottled CPX packets, drains them to the core
// via ready/valid, and never exposes the first half of an atomic pair without its partner.
module cpx_return_buffer
  import ccx_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int AFULL_MARGIN = 1,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpx_in_val,
  input  logic [CPX_WIDTH-1:0] cpx_in_data,
  output logic                 cpx_out_val,
  output logic [CPX_WIDTH-1:0] cpx_out_data,
  input  logic                 cpx_out_ready,
  output logic                 cpxbuf_afull,
  output logic                 cpxbuf_ovf_err,
  output logic [CW-1:0]        cpxbuf_count
);

  logic [CPX_WIDTH-1:0] mem_q   [DEPTH];
  logic                 first_q [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_d;
  logic          full, empty;
  logic          enq, deq, in_atomic, head_first;

  logic pair_phase_q, pair_phase_d;
  logic ovf_err_q, ovf_err_d;
  logic afull_q, afull_d;

  cpx_buf_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .enq_i     (enq),
    .deq_i     (deq),
    .wr_ptr_o  (wr_ptr),
    .rd_ptr_o  (rd_ptr),
    .count_o   (count),
    .count_d_o (count_d),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign in_atomic  = cpx_is_atomic(cpx_in_data);
  assign head_first = first_q[rd_ptr];

  // A first-half atomic at the head waits until its second half is also queued.
  assign cpx_out_val  = ~empty & (~head_first | (count >= CW'(2)));
  assign cpx_out_data = empty ? '0 : mem_q[rd_ptr];

  assign deq = cpx_out_val & cpx_out_ready;
  assign enq = cpx_in_val & (~full | deq);

  always_comb begin
    pair_phase_d = pair_phase_q;
    ovf_err_d    = ovf_err_q;
    if (enq && in_atomic) pair_phase_d = ~pair_phase_q;
    if (cpx_in_val && full && !deq) ovf_err_d = 1'b1;
    afull_d = (count_d >= CW'(DEPTH - AFULL_MARGIN));
  end

  // Storage is deliberately not reset; occupancy gates everything visible.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_ptr]   <= cpx_in_data;
      first_q[wr_ptr] <= in_atomic & ~pair_phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pair_phase_q <= 1'b0;
      ovf_err_q    <= 1'b0;
      afull_q      <= 1'b0;
    end else begin
      pair_phase_q <= pair_phase_d;
      ovf_err_q    <= ovf_err_d;
      afull_q      <= afull_d;
    end
  end

  assign cpxbuf_afull   = afull_q;
  assign cpxbuf_ovf_err = ovf_err_q;
  assign cpxbuf_count   = count;

endmodule

// File: tb/tb_cpx_return_buffer.sv
// Self-checking bench for cpx_return_buffer: directed scenarios plus randomized traffic
// against a queue-based reference model of the return buffer.
module tb_cpx_return_buffer;

  localparam int DEPTH = 4;
  localparam int AFULL_MARGIN = 1;
  localparam int W = 145;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpx_in_val;
  logic [W-1:0] cpx_in_data;
  logic         cpx_out_val;
  logic [W-1:0] cpx_out_data;
  logic         cpx_out_ready;
  logic         cpxbuf_afull;
  logic         cpxbuf_ovf_err;
  logic [2:0]   cpxbuf_count;

  int checks = 0;
  int failures = 0;

  cpx_return_buffer #(.DEPTH(DEPTH), .AFULL_MARGIN(AFULL_MARGIN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpx_in_val     (cpx_in_val),
    .cpx_in_data    (cpx_in_data),
    .cpx_out_val    (cpx_out_val),
    .cpx_out_data   (cpx_out_data),
    .cpx_out_ready  (cpx_out_ready),
    .cpxbuf_afull   (cpxbuf_afull),
    .cpxbuf_ovf_err (cpxbuf_ovf_err),
    .cpxbuf_count   (cpxbuf_count)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of packets, each carrying its "first half" tag.
  logic [W-1:0] mq[$];
  bit           mf[$];
  bit           m_phase;
  bit           m_ovf;
  bit           m_afull;

  function automatic bit exp_val();
    return (mq.size() >= 1) && (!mf[0] || mq.size() >= 2);
  endfunction

  function automatic logic [W-1:0] exp_data();
    logic [W-1:0] z;
    z = '0;
    return (mq.size() > 0) ? mq[0] : z;
  endfunction

  function automatic logic [W-1:0] rand_pkt(input bit atomic);
    logic [W-1:0] p;
    for (int i = 0; i < W; i++) p[i] = 1'($urandom_range(0, 1));
    p[144] = 1'b1;
    p[129] = atomic;
    return p;
  endfunction

  task automatic drive(input bit v, input logic [W-1:0] d, input bit r);
    cpx_in_val    = v;
    cpx_in_data   = d;
    cpx_out_ready = r;
  endtask

  // Advance one clock and update the model from the pre-edge inputs.
  task automatic tick();
    bit d, e, full;
    logic [W-1:0] din;
    if (!rst_n) begin
      @(posedge clk); #1;
      mq.delete(); mf.delete();
      m_phase = 0; m_ovf = 0; m_afull = 0;
      return;
    end
    din  = cpx_in_data;
    d    = exp_val() && cpx_out_ready;
    full = (mq.size() == DEPTH);
    e    = cpx_in_val && (!full || d);
    if (d) $display("deq data=%h", mq[0]);
    @(posedge clk); #1;
    if (cpx_in_val && full && !d) m_ovf = 1;
    if (d) begin void'(mq.pop_front()); void'(mf.pop_front()); end
    if (e) begin
      mq.push_back(din);
      mf.push_back(din[129] & ~m_phase);
      if (din[129]) m_phase = ~m_phase;
    end
    m_afull = (mq.size() >= DEPTH - AFULL_MARGIN);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, '0, 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cpx_out_val !== 1'b0) begin failures++; $display("FAIL reset_val got=%b exp=0", cpx_out_val); end
    checks++; if (cpx_out_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", cpx_out_data); end
    checks++; if (cpxbuf_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cpxbuf_count); end
    checks++; if (cpxbuf_afull !== 1'b0) begin failures++; $display("FAIL reset_afull got=%b exp=0", cpxbuf_afull); end
    checks++; if (cpxbuf_ovf_err !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", cpxbuf_ovf_err); end
  endtask

  task automatic test_single();
    logic [W-1:0] p;
    p = rand_pkt(0);
    drive(1, p, 1);
    tick();
    checks++; if (cpx_out_val !== 1'b1) begin failures++; $display("FAIL single_val got=%b exp=1", cpx_out_val); end
    checks++; if (cpx_out_data !== p) begin failures++; $display("FAIL single_data got=%h exp=%h", cpx_out_data, p); end
    checks++; if (cpxbuf_count !== 3'd1) begin failures++; $display("FAIL single_count1 got=%0d exp=1", cpxbuf_count); end
    drive(0, '0, 1);
    tick();
    checks++; if (cpxbuf_count !== 3'd0) begin failures++; $display("FAIL single_count0 got=%0d exp=0", cpxbuf_count); end
    checks++; if (cpx_out_val !== 1'b0) begin failures++; $display("FAIL single_val0 got=%b exp=0", cpx_out_val); end
  endtask

  task automatic test_atomic_split();
    logic [W-1:0] a1, a2;
    a1 = rand_pkt(1);
    a2 = rand_pkt(1);
    drive(1, a1, 1);
    tick();
    for (int i = 1; i <= 4; i++) begin
      checks++; if (cpx_out_val !== 1'b0) begin failures++; $display("FAIL atomic_hold t%0d got=%b exp=0", i, cpx_out_val); end
      if (i < 4) drive(0, '0, 1); else drive(1, a2, 1);
      tick();
    end
    checks++; if (cpx_out_val !== 1'b1 || cpx_out_data !== a1) begin failures++; $display("FAIL atomic_a1 val=%b got=%h exp=%h", cpx_out_val, cpx_out_data, a1); end
    drive(0, '0, 1);
    tick();
    checks++; if (cpx_out_val !== 1'b1 || cpx_out_data !== a2) begin failures++; $display("FAIL atomic_a2 val=%b got=%h exp=%h", cpx_out_val, cpx_out_data, a2); end
    tick();
    checks++; if (cpx_out_val !== 1'b0) begin failures++; $display("FAIL atomic_empty got=%b exp=0", cpx_out_val); end
  endtask

  task automatic test_fill();
    logic [W-1:0] pk[4];
    for (int k = 0; k < 4; k++) begin
      pk[k] = rand_pkt(0);
      drive(1, pk[k], 0);
      tick();
      checks++; if (cpxbuf_count !== 3'(k + 1)) begin failures++; $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, cpxbuf_count, k + 1); end
      checks++; if (cpxbuf_afull !== (k >= 2)) begin failures++; $display("FAIL fill_afull k=%0d got=%b exp=%b", k, cpxbuf_afull, k >= 2); end
      checks++; if (cpxbuf_ovf_err !== 1'b0) begin failures++; $display("FAIL fill_noovf k=%0d got=%b exp=0", k, cpxbuf_ovf_err); end
    end
    drive(1, rand_pkt(0), 0);
    tick();
    checks++; if (cpxbuf_ovf_err !== 1'b1) begin failures++; $display("FAIL fill_ovf got=%b exp=1", cpxbuf_ovf_err); end
    checks++; if (cpxbuf_count !== 3'd4) begin failures++; $display("FAIL fill_count_full got=%0d exp=4", cpxbuf_count); end
    drive(0, '0, 0);
    tick();
    checks++; if (cpxbuf_ovf_err !== 1'b1) begin failures++; $display("FAIL fill_ovf_sticky got=%b exp=1", cpxbuf_ovf_err); end
    drive(0, '0, 1);
    for (int k = 0; k < 4; k++) begin
      checks++; if (cpx_out_val !== 1'b1 || cpx_out_data !== pk[k]) begin failures++; $display("FAIL fill_drain k=%0d val=%b got=%h exp=%h", k, cpx_out_val, cpx_out_data, pk[k]); end
      tick();
    end
    checks++; if (cpxbuf_ovf_err !== 1'b1 || cpxbuf_count !== 3'd0) begin failures++; $display("FAIL fill_end ovf=%b count=%0d exp ovf=1 count=0", cpxbuf_ovf_err, cpxbuf_count); end
    do_reset();
  endtask

  task automatic test_full_enq_deq();
    for (int k = 0; k < 4; k++) begin drive(1, rand_pkt(0), 0); tick(); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (cpx_out_data !== exp_data()) begin failures++; $display("FAIL full_ed_data k=%0d got=%h exp=%h", k, cpx_out_data, exp_data()); end
      drive(1, rand_pkt(0), 1);
      tick();
      checks++; if (cpxbuf_count !== 3'd4) begin failures++; $display("FAIL full_ed_count k=%0d got=%0d exp=4", k, cpxbuf_count); end
      checks++; if (cpxbuf_ovf_err !== 1'b0) begin failures++; $display("FAIL full_ed_ovf k=%0d got=%b exp=0", k, cpxbuf_ovf_err); end
    end
    drive(0, '0, 1);
    for (int k = 0; k < 5; k++) begin
      checks++; if (cpx_out_val !== exp_val() || cpx_out_data !== exp_data()) begin failures++; $display("FAIL full_ed_drain k=%0d val=%b got=%h exp=%h", k, cpx_out_val, cpx_out_data, exp_data()); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] sent[$];
    logic [W-1:0] got[$];
    logic [W-1:0] held;
    logic [W-1:0] p;
    bit stall, r;
    int n = 0;
    for (int c = 0; c < 45; c++) begin
      r = (c % 2 == 0);
      if (c % 3 == 0 && n < 10) begin
        p = rand_pkt(0);
        sent.push_back(p);
        n++;
        drive(1, p, r);
      end else drive(0, '0, r);
      stall = cpx_out_val && !r;
      held = exp_data();
      if (cpx_out_val && r) got.push_back(cpx_out_data);
      tick();
      if (stall) begin
        checks++; if (cpx_out_val !== 1'b1 || cpx_out_data !== held) begin failures++; $display("FAIL bp_stable c=%0d val=%b got=%h exp=%h", c, cpx_out_val, cpx_out_data, held); end
      end
    end
    checks++; if (got.size() != sent.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", got.size(), sent.size()); end
    for (int i = 0; i < sent.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== sent[i]) begin failures++; $display("FAIL bp_order i=%0d got=%h exp=%h", i, got[i], sent[i]); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 99) < 50), rand_pkt($urandom_range(0, 3) == 0), ($urandom_range(0, 99) < 60));
      tick();
      checks++; if (cpx_out_val !== exp_val()) begin failures++; $display("FAIL rnd_val c=%0d got=%b exp=%b", c, cpx_out_val, exp_val()); end
      checks++; if (cpx_out_data !== exp_data()) begin failures++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, cpx_out_data, exp_data()); end
      checks++; if (cpxbuf_count !== 3'(mq.size())) begin failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, cpxbuf_count, mq.size()); end
      checks++; if (cpxbuf_afull !== m_afull || cpxbuf_ovf_err !== m_ovf) begin failures++; $display("FAIL rnd_flags c=%0d afull=%b/%b ovf=%b/%b", c, cpxbuf_afull, m_afull, cpxbuf_ovf_err, m_ovf); end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] a1, a2;
    do_reset();
    drive(1, rand_pkt(0), 0); tick();
    drive(1, rand_pkt(1), 0); tick();
    drive(1, rand_pkt(0), 0); tick();
    drive(1, rand_pkt(0), 0); tick();
    drive(1, rand_pkt(0), 0); tick();
    drive(0, '0, 1); tick();
    checks++; if (cpxbuf_count !== 3'd3 || cpxbuf_ovf_err !== 1'b1) begin failures++; $display("FAIL rmid_pre count=%0d ovf=%b exp count=3 ovf=1", cpxbuf_count, cpxbuf_ovf_err); end
    rst_n = 1'b0;
    drive(0, '0, 0);
    tick();
    rst_n = 1'b1;
    checks++; if (cpx_out_val !== 1'b0) begin failures++; $display("FAIL rmid_val got=%b exp=0", cpx_out_val); end
    checks++; if (cpxbuf_count !== 3'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", cpxbuf_count); end
    checks++; if (cpxbuf_afull !== 1'b0 || cpxbuf_ovf_err !== 1'b0) begin failures++; $display("FAIL rmid_flags afull=%b ovf=%b exp 0 0", cpxbuf_afull, cpxbuf_ovf_err); end
    a1 = rand_pkt(1);
    a2 = rand_pkt(1);
    drive(1, a1, 1); tick();
    checks++; if (cpx_out_val !== 1'b0) begin failures++; $display("FAIL rmid_a1_hold got=%b exp=0", cpx_out_val); end
    drive(1, a2, 1); tick();
    checks++; if (cpx_out_val !== 1'b1 || cpx_out_data !== a1) begin failures++; $display("FAIL rmid_a1 val=%b got=%h exp=%h", cpx_out_val, cpx_out_data, a1); end
    drive(0, '0, 1); tick();
    checks++; if (cpx_out_val !== 1'b1 || cpx_out_data !== a2) begin failures++; $display("FAIL rmid_a2 val=%b got=%h exp=%h", cpx_out_val, cpx_out_data, a2); end
    tick();
    checks++; if (cpx_out_val !== 1'b0 || cpxbuf_count !== 3'd0) begin failures++; $display("FAIL rmid_end val=%b count=%0d exp 0 0", cpx_out_val, cpxbuf_count); end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, '0, 0);
    m_phase = 0; m_ovf = 0; m_afull = 0;
    test_reset();
    test_single();
    test_atomic_split();
    test_fill();
    test_full_enq_deq();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
